// File: rtl/jt51_pkg.sv
// Shared constants for the jt51 mixer slice.
//   SLOTS    : operator slots per sample frame
//   SLOT_W   : width of the slot counter
//   OPW_DEF  : default operator output width
//   OUTW_DEF : default output sample width
//   RL_LEFT / RL_RIGHT : bit positions inside the per-slot rl enable
package jt51_pkg;

    localparam int unsigned SLOTS    = 32;
    localparam int unsigned SLOT_W   = $clog2(SLOTS);
    localparam int unsigned OPW_DEF  = 14;
    localparam int unsigned OUTW_DEF = 16;
    localparam int unsigned RL_LEFT  = 1;
    localparam int unsigned RL_RIGHT = 0;

endpackage

// File: rtl/jt51_mix_acc_if.sv
// Slot-stream / stereo-sample bundle between the operator pipeline, the mixer and
// the output stage.
//   cen, zero, op_out, carrier, rl : slot stream into the mixer
//   left, right, sample, slot      : mixed stereo sample and debug slot counter
// Modports:
//   master : the producer side (drives the slot stream, observes the mix)
//   slave  : the mixer itself
interface jt51_mix_acc_if
    import jt51_pkg::*;
#(
    parameter int unsigned OPW  = OPW_DEF,
    parameter int unsigned OUTW = OUTW_DEF
);

    logic                     cen;
    logic                     zero;
    logic signed [OPW-1:0]    op_out;
    logic                     carrier;
    logic [1:0]               rl;
    logic signed [OUTW-1:0]   left;
    logic signed [OUTW-1:0]   right;
    logic                     sample;
    logic [SLOT_W-1:0]        slot;

    modport master (
        output cen, zero, op_out, carrier, rl,
        input  left, right, sample, slot
    );

    modport slave (
        input  cen, zero, op_out, carrier, rl,
        output left, right, sample, slot
    );

endinterface

// File: rtl/jt51_mix_sat.sv
// Combinational saturator from the accumulator width down to the output width.
//   din  : signed ACCW-bit sum
//   dout : signed OUTW-bit value, clamped to [-2^(OUTW-1), 2^(OUTW-1)-1]
// No scaling: in-range values pass through unchanged.
module jt51_mix_sat #(
    parameter int unsigned ACCW = 18,
    parameter int unsigned OUTW = 16
) (
    input  logic signed [ACCW-1:0] din,
    output logic signed [OUTW-1:0] dout
);

    if (ACCW > OUTW) begin : g_sat
        // The value fits iff every bit from the output sign bit upwards agrees.
        logic [ACCW-OUTW:0] top_bits;
        assign top_bits = din[ACCW-1:OUTW-1];

        always_comb begin
            if (top_bits == '0 || top_bits == '1) begin
                dout = din[OUTW-1:0];
            end else if (din[ACCW-1]) begin
                dout = {1'b1, {(OUTW-1){1'b0}}};
            end else begin
                dout = {1'b0, {(OUTW-1){1'b1}}};
            end
        end
    end else begin : g_ext
        // Output is at least as wide: plain sign extension, nothing can clip.
        assign dout = OUTW'(din);
    end

endmodule

// File: rtl/jt51_mix_acc.sv
// Stereo carrier mixer.
// Sums carrier operator outputs of one 32-slot frame into left/right accumulators
// according to each slot's rl enables, and on the frame-start slot (zero) presents
// the saturated sums as one stereo sample with a one-clk sample pulse.
//   clk, rst : clock, asynchronous active-high reset
//   bus      : slave side of jt51_mix_acc_if (slot stream in, stereo sample out)
// A contribution on any cen slot shows up at the next zero edge; the zero slot's
// own contribution is loaded into the fresh accumulators so nothing is lost.
module jt51_mix_acc
    import jt51_pkg::*;
#(
    parameter int unsigned OPW  = OPW_DEF,
    parameter int unsigned OUTW = OUTW_DEF,
    parameter int unsigned ACCW = OPW + 4
) (
    input  logic                 clk,
    input  logic                 rst,
    jt51_mix_acc_if.slave        bus
);

    logic [SLOT_W-1:0]      slot_q, slot_d;
    logic signed [ACCW-1:0] acc_l_q, acc_l_d;
    logic signed [ACCW-1:0] acc_r_q, acc_r_d;
    logic signed [OUTW-1:0] left_q, left_d;
    logic signed [OUTW-1:0] right_q, right_d;
    logic                   sample_q, sample_d;

    logic signed [ACCW-1:0] contrib;
    logic signed [ACCW-1:0] term_l;
    logic signed [ACCW-1:0] term_r;
    logic signed [OUTW-1:0] sat_l;
    logic signed [OUTW-1:0] sat_r;

    // Per-slot contribution: modulators never reach the mix.
    always_comb begin
        contrib = '0;
        if (bus.carrier) begin
            contrib = {{(ACCW-OPW){bus.op_out[OPW-1]}}, bus.op_out};
        end
        term_l = bus.rl[RL_LEFT]  ? contrib : '0;
        term_r = bus.rl[RL_RIGHT] ? contrib : '0;
    end

    jt51_mix_sat #(
        .ACCW (ACCW),
        .OUTW (OUTW)
    ) u_sat_l (
        .din  (acc_l_q),
        .dout (sat_l)
    );

    jt51_mix_sat #(
        .ACCW (ACCW),
        .OUTW (OUTW)
    ) u_sat_r (
        .din  (acc_r_q),
        .dout (sat_r)
    );

    always_comb begin
        slot_d   = slot_q;
        acc_l_d  = acc_l_q;
        acc_r_d  = acc_r_q;
        left_d   = left_q;
        right_d  = right_q;
        sample_d = 1'b0;  // pulse lasts exactly one clk, independent of cen
        if (bus.cen) begin
            if (bus.zero) begin
                // Frame close: publish the old sums, restart with slot 0's terms.
                slot_d   = SLOT_W'(1);
                left_d   = sat_l;
                right_d  = sat_r;
                acc_l_d  = term_l;
                acc_r_d  = term_r;
                sample_d = 1'b1;
            end else begin
                slot_d  = slot_q + SLOT_W'(1);  // natural wrap 31 -> 0
                acc_l_d = acc_l_q + term_l;
                acc_r_d = acc_r_q + term_r;
            end
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            slot_q   <= '0;
            acc_l_q  <= '0;
            acc_r_q  <= '0;
            left_q   <= '0;
            right_q  <= '0;
            sample_q <= 1'b0;
        end else begin
            slot_q   <= slot_d;
            acc_l_q  <= acc_l_d;
            acc_r_q  <= acc_r_d;
            left_q   <= left_d;
            right_q  <= right_d;
            sample_q <= sample_d;
        end
    end

    assign bus.left   = left_q;
    assign bus.right  = right_q;
    assign bus.sample = sample_q;
    assign bus.slot   = slot_q;

endmodule

// File: tb/tb_jt51_mix_acc.sv
// Directed bench for jt51_mix_acc: frame vectors from a table plus hand-written
// sequences for reset, cen gating, back-to-back zeros and a missing zero.
module tb_jt51_mix_acc;

    logic clk;
    logic rst;

    jt51_mix_acc_if bus ();

    jt51_mix_acc dut (
        .clk (clk),
        .rst (rst),
        .bus (bus.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int n_vec;
    int n_bad;

    typedef struct {
        int         first;   // first slot (1..31) carrying op1
        int         n1;
        int         op1;
        int         n2;      // slots right after the op1 run carrying op2
        int         op2;
        logic       car;
        logic [1:0] rl;
        int         exp_l;
        int         exp_r;
    } vec_t;

    vec_t vecs[9];
    int   prev_l;
    int   prev_r;

    task automatic chk(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_bad++;
            $display("FAIL %s: got %0d, expected %0d", name, act, exp);
        end
    endtask

    // Drive one clk cycle of stream inputs; returns #1 after the capturing edge.
    task automatic step(input logic c, input logic z, input int op,
                        input logic car, input logic [1:0] r);
        bus.cen     = c;
        bus.zero    = z;
        bus.op_out  = 14'(op);
        bus.carrier = car;
        bus.rl      = r;
        @(posedge clk);
        #1;
    endtask

    function automatic int s_left();
        return int'($signed(bus.left));
    endfunction

    function automatic int s_right();
        return int'($signed(bus.right));
    endfunction

    // One full frame: zero slot (closes the previous frame) then slots 1..31.
    task automatic run_frame(input vec_t v);
        step(1'b1, 1'b1, 0, 1'b0, 2'b00);
        chk("frame_left", s_left(), prev_l);
        chk("frame_right", s_right(), prev_r);
        chk("frame_sample", int'(bus.sample), 1);
        chk("frame_slot1", int'(bus.slot), 1);
        for (int s = 1; s < 32; s++) begin
            if (s >= v.first && s < v.first + v.n1) begin
                step(1'b1, 1'b0, v.op1, v.car, v.rl);
            end else if (s >= v.first + v.n1 && s < v.first + v.n1 + v.n2) begin
                step(1'b1, 1'b0, v.op2, v.car, v.rl);
            end else begin
                step(1'b1, 1'b0, 0, 1'b0, 2'b00);
            end
            if (s == 1) chk("frame_sample_clr", int'(bus.sample), 0);
        end
        chk("frame_slot_wrap", int'(bus.slot), 0);
        prev_l = v.exp_l;
        prev_r = v.exp_r;
    endtask

    initial begin
        int highs;
        n_vec  = 0;
        n_bad  = 0;
        prev_l = 0;
        prev_r = 0;

        vecs[0] = '{5, 1, 1234, 0, 0, 1'b1, 2'b10, 1234, 0};
        vecs[1] = '{5, 1, 8000, 0, 0, 1'b0, 2'b11, 0, 0};
        vecs[2] = '{1, 8, 8191, 0, 0, 1'b1, 2'b11, 32767, 32767};
        vecs[3] = '{1, 8, -8192, 0, 0, 1'b1, 2'b11, -32768, -32768};
        vecs[4] = '{1, 4, 4000, 4, -4000, 1'b1, 2'b11, 0, 0};
        vecs[5] = '{3, 2, -1500, 0, 0, 1'b1, 2'b01, 0, -3000};
        vecs[6] = '{10, 3, 7000, 0, 0, 1'b1, 2'b10, 21000, 0};
        vecs[7] = '{20, 5, 7000, 0, 0, 1'b1, 2'b11, 32767, 32767};
        vecs[8] = '{31, 1, -77, 0, 0, 1'b1, 2'b11, -77, -77};

        // Reset state.
        rst         = 1'b1;
        bus.cen     = 1'b0;
        bus.zero    = 1'b0;
        bus.op_out  = '0;
        bus.carrier = 1'b0;
        bus.rl      = 2'b00;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_left", s_left(), 0);
        chk("rst_right", s_right(), 0);
        chk("rst_sample", int'(bus.sample), 0);
        chk("rst_slot", int'(bus.slot), 0);
        rst = 1'b0;

        // Reset mid-frame discards the partial sums.
        step(1'b1, 1'b1, 0, 1'b0, 2'b00);
        chk("pre_sample", int'(bus.sample), 1);
        repeat (10) step(1'b1, 1'b0, 1000, 1'b1, 2'b11);
        chk("pre_slot", int'(bus.slot), 11);
        #2 rst = 1'b1;
        #1;
        chk("async_rst_slot", int'(bus.slot), 0);
        @(posedge clk);
        #1 rst = 1'b0;
        for (int i = 0; i < 5; i++) begin
            step(1'b1, 1'b0, 0, 1'b0, 2'b00);
            chk("post_rst_no_sample", int'(bus.sample), 0);
        end
        chk("post_rst_slot", int'(bus.slot), 5);

        // Table-driven frames; each frame's zero checks the previous frame.
        foreach (vecs[i]) run_frame(vecs[i]);

        // Slot-0 carry with cen toggling; cen=0 zeros must be ignored.
        step(1'b1, 1'b1, 500, 1'b1, 2'b01);
        chk("last_vec_left", s_left(), prev_l);
        chk("last_vec_right", s_right(), prev_r);
        chk("carry_sample", int'(bus.sample), 1);
        for (int s = 1; s < 32; s++) begin
            step(1'b1, 1'b0, 0, 1'b0, 2'b00);
            chk("gate_slot", int'(bus.slot), (s + 1) % 32);
            step(1'b0, 1'b1, 999, 1'b1, 2'b11);
            chk("gate_slot_hold", int'(bus.slot), (s + 1) % 32);
            chk("gate_no_sample", int'(bus.sample), 0);
            if (s == 16) chk("gate_left_held", s_left(), prev_l);
        end

        // Back-to-back zeros: one-slot frames.
        step(1'b1, 1'b1, 300, 1'b1, 2'b11);
        chk("carry_right", s_right(), 500);
        chk("carry_left", s_left(), 0);
        chk("carry_sample2", int'(bus.sample), 1);
        step(1'b1, 1'b1, 0, 1'b0, 2'b00);
        chk("b2b_left", s_left(), 300);
        chk("b2b_right", s_right(), 300);
        chk("b2b_sample", int'(bus.sample), 1);
        step(1'b1, 1'b1, 0, 1'b0, 2'b00);
        chk("b2b_empty_left", s_left(), 0);

        // Missing zero: counter keeps wrapping, no sample is emitted.
        highs = 0;
        for (int i = 0; i < 40; i++) begin
            step(1'b1, 1'b0, 0, 1'b0, 2'b00);
            if (bus.sample) highs++;
        end
        chk("nozero_samples", highs, 0);
        chk("nozero_slot", int'(bus.slot), 9);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
        $finish;
    end

endmodule
